// File: rtl/ram_read_checker_pkg.sv
// Shared definitions for the RAM read-back checker and the pattern writer:
// the checker state encoding, the default seed and the 16-bit LFSR next-state function.
package ram_read_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Fibonacci LFSR step; the writer uses the same function so both streams match.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
    lfsr16_next = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

endpackage

// File: rtl/ram_read_checker_lfsr16.sv
// 16-bit pattern LFSR with synchronous load-to-seed and advance enable.
module lfsr16
  import ram_read_checker_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  output logic [15:0] state
);

  logic [15:0] state_r;

  // Load wins over advance so every restart begins exactly at SEED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SEED;
    end else if (load) begin
      state_r <= SEED;
    end else if (adv) begin
      state_r <= lfsr16_next(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/ram_read_checker.sv
// Sweeps one RAM read port over the full address range and compares each returned
// word against the regenerated LFSR pattern, reporting pass, error count and first failure.
module ram_read_checker
  import ram_read_checker_pkg::*;
#(
  parameter int          ADDR_W = 8,
  parameter int          DATA_W = 16,
  parameter int          RD_LAT = 1,
  parameter logic [15:0] SEED   = DEFAULT_SEED
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_en,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [DATA_W-1:0] i_dout,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ADDR_W:0]   o_err_cnt,
  output logic [ADDR_W-1:0] o_first_err_addr,
  output logic              o_first_err_vld
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ERR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r;
  logic              en_r;
  logic              busy_r;
  logic              done_r;
  logic              pass_r;
  logic [ADDR_W-1:0] addr_r;
  logic [RD_LAT-1:0] pipe_vld_r;
  logic [ADDR_W-1:0] pipe_addr_r [RD_LAT];
  logic [ADDR_W:0]   err_cnt_r;
  logic [ADDR_W:0]   err_cnt_nxt_s;
  logic [ADDR_W-1:0] first_err_addr_r;
  logic              first_err_vld_r;
  logic [15:0]       lfsr_s;
  logic              start_acc_s;
  logic              abort_s;
  logic              cmp_vld_s;
  logic              mismatch_s;
  logic              upstream_busy_s;

  // Control decode and compare of the word qualified by the last pipeline stage.
  always_comb begin
    start_acc_s     = (state_r == ST_IDLE) && i_start && !i_abort;
    abort_s         = (state_r != ST_IDLE) && i_abort;
    cmp_vld_s       = pipe_vld_r[RD_LAT-1];
    upstream_busy_s = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      upstream_busy_s = upstream_busy_s | pipe_vld_r[i];
    end
    if (cmp_vld_s) begin
      mismatch_s = (i_dout != lfsr_s[DATA_W-1:0]);
    end else begin
      mismatch_s = 1'b0;
    end
    if (mismatch_s) begin
      err_cnt_nxt_s = err_cnt_r + ERR_ONE;
    end else begin
      err_cnt_nxt_s = err_cnt_r;
    end
  end

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (i_sys_clk),
    .rst_n (i_rst_n),
    .load  (start_acc_s),
    .adv   (cmp_vld_s),
    .state (lfsr_s)
  );

  // Sweep FSM with registered RAM controls and status outputs.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      en_r    <= 1'b0;
      addr_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_acc_s) begin
            state_r <= ST_READ;
            en_r    <= 1'b1;
            addr_r  <= '0;
            busy_r  <= 1'b1;
            pass_r  <= 1'b0;
          end
        end
        ST_READ: begin
          if (i_abort) begin
            state_r <= ST_IDLE;
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
          end else if (addr_r == ADDR_MAX) begin
            state_r <= ST_DRAIN;
            en_r    <= 1'b0;
          end else begin
            addr_r <= addr_r + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          // Pipeline is empty after this edge once only the compare stage holds data.
          if (i_abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (!upstream_busy_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            pass_r  <= (err_cnt_nxt_s == '0);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          en_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency pipeline carrying {valid, addr} alongside the RAM.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_vld_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_addr_r[i] <= '0;
      end
    end else if (abort_s) begin
      pipe_vld_r <= '0;
    end else begin
      pipe_vld_r[0]  <= en_r;
      pipe_addr_r[0] <= addr_r;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_r[i]  <= pipe_vld_r[i-1];
        pipe_addr_r[i] <= pipe_addr_r[i-1];
      end
    end
  end

  // Error count and first-failure capture.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_r        <= '0;
      first_err_addr_r <= '0;
      first_err_vld_r  <= 1'b0;
    end else if (start_acc_s) begin
      err_cnt_r        <= '0;
      first_err_addr_r <= '0;
      first_err_vld_r  <= 1'b0;
    end else if (mismatch_s) begin
      err_cnt_r <= err_cnt_nxt_s;
      if (!first_err_vld_r) begin
        first_err_vld_r  <= 1'b1;
        first_err_addr_r <= pipe_addr_r[RD_LAT-1];
      end
    end
  end

  assign o_en             = en_r;
  assign o_we             = 1'b0;
  assign o_addr           = addr_r;
  assign o_busy           = busy_r;
  assign o_done           = done_r;
  assign o_pass           = pass_r;
  assign o_err_cnt        = err_cnt_r;
  assign o_first_err_addr = first_err_addr_r;
  assign o_first_err_vld  = first_err_vld_r;

endmodule

// File: tb/tb_ram_read_checker.sv
// Scoreboard bench: two checkers (read latency 1 and 2) against behavioral RAMs
// preloaded with the writer's LFSR pattern, with directed corruptions and control events.
module tb_ram_read_checker;

  typedef struct {
    logic [8:0] err_cnt;
    logic [7:0] first_addr;
    logic       first_vld;
    logic       pass;
    int         done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, abort_a, start_b, abort_b;
  logic        en_a, we_a, busy_a, done_a, pass_a, fev_a;
  logic        en_b, we_b, busy_b, done_b, pass_b, fev_b;
  logic [7:0]  addr_a, fea_a, addr_b, fea_b;
  logic [8:0]  err_cnt_a, err_cnt_b;
  logic [15:0] dout_a, dout_b, q1_b;
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ram_read_checker #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .SEED(16'hACE1)) dut_a (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_abort(abort_a),
    .o_en(en_a), .o_we(we_a), .o_addr(addr_a), .i_dout(dout_a),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a), .o_err_cnt(err_cnt_a),
    .o_first_err_addr(fea_a), .o_first_err_vld(fev_a)
  );

  ram_read_checker #(.ADDR_W(8), .DATA_W(16), .RD_LAT(2), .SEED(16'hACE1)) dut_b (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_abort(abort_b),
    .o_en(en_b), .o_we(we_b), .o_addr(addr_b), .i_dout(dout_b),
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b), .o_err_cnt(err_cnt_b),
    .o_first_err_addr(fea_b), .o_first_err_vld(fev_b)
  );

  // Behavioral RAMs: single-register read and read with output register.
  always @(posedge clk) begin
    if (en_a) dout_a <= mem_a[addr_a];
    if (en_b) q1_b <= mem_b[addr_b];
    dout_b <= q1_b;
  end

  function automatic logic [15:0] pat_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: pop an expectation whenever a checker signals completion.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_done actual=1 required=0");
      end else begin
        ea = q_a.pop_front();
        chk("a_err_cnt", err_cnt_a, ea.err_cnt);
        chk("a_first_addr", fea_a, ea.first_addr);
        chk("a_first_vld", fev_a, ea.first_vld);
        chk("a_pass", pass_a, ea.pass);
        chk("a_done_cycle", cyc, ea.done_cyc);
        chk("a_busy_at_done", busy_a, 0);
      end
    end
    if (rst_n === 1'b1 && done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_done actual=1 required=0");
      end else begin
        eb = q_b.pop_front();
        chk("b_err_cnt", err_cnt_b, eb.err_cnt);
        chk("b_first_addr", fea_b, eb.first_addr);
        chk("b_first_vld", fev_b, eb.first_vld);
        chk("b_pass", pass_b, eb.pass);
        chk("b_done_cycle", cyc, eb.done_cyc);
      end
    end
  end

  // Called at posedge+1; done is expected 258 (A) or 259 (B) cycles after the start edge.
  task automatic sweep_a(input bit expect_done, input logic [8:0] ec, input logic [7:0] fa,
                         input logic fv, input logic p);
    exp_t e;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    if (expect_done) begin
      e.err_cnt = ec; e.first_addr = fa; e.first_vld = fv; e.pass = p;
      e.done_cyc = cyc + 257;
      q_a.push_back(e);
    end
  endtask

  task automatic sweep_b(input logic [8:0] ec, input logic [7:0] fa, input logic fv, input logic p);
    exp_t e;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    e.err_cnt = ec; e.first_addr = fa; e.first_vld = fv; e.pass = p;
    e.done_cyc = cyc + 258;
    q_b.push_back(e);
  endtask

  task automatic drain(input string name);
    repeat (300) @(posedge clk);
    #1;
    chk(name, q_a.size() + q_b.size(), 0);
  endtask

  task automatic wait_addr_a(input logic [7:0] target);
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (en_a === 1'b1 && addr_a === target) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL wait_addr_a actual=timeout required=%0h", target);
    end
  endtask

  initial begin
    logic [15:0] s;
    rst_n = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    s = 16'hACE1;
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = s;
      mem_b[k] = s;
      s = pat_next(s);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs_a", {en_a, we_a, addr_a, busy_a, done_a, pass_a, err_cnt_a, fea_a, fev_a}, 0);
    chk("rst_outputs_b", {en_b, we_b, addr_b, busy_b, done_b, pass_b, err_cnt_b, fea_b, fev_b}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean sweep, latency 1.
    sweep_a(1'b1, 9'd0, 8'h00, 1'b0, 1'b1);
    chk("a_busy_after_start", busy_a, 1);
    chk("a_en_addr0", {en_a, addr_a}, {1'b1, 8'h00});
    drain("clean_a_drained");
    chk("a_pass_held", pass_a, 1);

    // Single bit flip at 0x37.
    mem_a[8'h37] = mem_a[8'h37] ^ 16'h0001;
    sweep_a(1'b1, 9'd1, 8'h37, 1'b1, 1'b0);
    drain("corrupt37_drained");
    mem_a[8'h37] = mem_a[8'h37] ^ 16'h0001;

    // First and last address corrupted; a wrap would re-read 0x00 and count three.
    mem_a[8'h00] = mem_a[8'h00] ^ 16'h0001;
    mem_a[8'hFF] = mem_a[8'hFF] ^ 16'h8000;
    sweep_a(1'b1, 9'd2, 8'h00, 1'b1, 1'b0);
    drain("corrupt_ends_drained");
    chk("a_en_idle_after_sweep", en_a, 0);
    mem_a[8'h00] = mem_a[8'h00] ^ 16'h0001;
    mem_a[8'hFF] = mem_a[8'hFF] ^ 16'h8000;

    // Latency 2 with 0x80 corrupted.
    mem_b[8'h80] = mem_b[8'h80] ^ 16'h0100;
    sweep_b(9'd1, 8'h80, 1'b1, 1'b0);
    drain("corrupt80_b_drained");
    mem_b[8'h80] = mem_b[8'h80] ^ 16'h0100;

    // Abort at address 100: no done may appear.
    sweep_a(1'b0, 9'd0, 8'h00, 1'b0, 1'b0);
    wait_addr_a(8'd100);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    chk("abort_en", en_a, 0);
    chk("abort_busy", busy_a, 0);
    drain("abort_no_done");
    chk("abort_pass", pass_a, 0);

    // Restart after abort with a stray start mid-sweep.
    sweep_a(1'b1, 9'd0, 8'h00, 1'b0, 1'b1);
    wait_addr_a(8'd50);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("stray_start_addr", addr_a, 8'd51);
    drain("restart_drained");

    // Asynchronous reset mid-sweep, then a normal sweep.
    sweep_a(1'b0, 9'd0, 8'h00, 1'b0, 1'b0);
    wait_addr_a(8'd50);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs_a", {en_a, we_a, addr_a, busy_a, done_a, pass_a, err_cnt_a, fea_a, fev_a}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    sweep_a(1'b1, 9'd0, 8'h00, 1'b0, 1'b1);
    drain("post_reset_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_read_checker.md
# ram_read_checker

Synthesizable read-back checker for the on-chip block RAM under test. On a start request it sweeps one RAM port from address 0 to the top address. It regenerates the expected data stream with an LFSR seeded identically to the pattern writer and compares every returned word, accounting for the RAM read latency. It reports pass/fail, error count and first failing address. It is the reader counterpart to the existing random-pattern write stimulus and sits between the RAM's read port and the self-test status logic.

## Interface
Parameters:
- ADDR_W, 8, RAM address width; depth = 2^ADDR_W.
- DATA_W, 16, RAM data width; legal range 1..16.
- RD_LAT, 1, RAM read latency in cycles from en/addr to valid dout; legal values 1 or 2 (2 = output register enabled).
- SEED, 16'hACE1, LFSR seed; must be non-zero.

Ports:
- i_sys_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  single-cycle start request; honoured only in IDLE.
- i_abort  in  1  synchronous abort; returns to IDLE without o_done.
- o_en  out  1  RAM port enable.
- o_we  out  1  RAM write enable; tied 0.
- o_addr  out  ADDR_W  RAM address.
- i_dout  in  DATA_W  RAM read data.
- o_busy  out  1  high from the cycle after accepted start until o_done.
- o_done  out  1  one-cycle pulse at sweep completion.
- o_pass  out  1  1 when the last completed sweep had zero errors; held until next start.
- o_err_cnt  out  ADDR_W+1  mismatch count of current/last sweep.
- o_first_err_addr  out  ADDR_W  address of first mismatch.
- o_first_err_vld  out  1  o_first_err_addr is valid.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: i_start=1 → READ. Clear o_err_cnt, o_pass, o_first_err_vld, o_first_err_addr. Load the LFSR with SEED.
- READ: o_en=1, o_addr increments by 1 per cycle from 0. On o_addr = 2^ADDR_W−1 → DRAIN. The address does not wrap into a second pass.
- DRAIN: o_en=0. Stay until the compare pipeline is empty, then → DONE.
- DONE: o_done=1 for one cycle. o_pass = (o_err_cnt==0). → IDLE.
- Compare pipeline: RD_LAT-deep shift register carrying {valid, addr}. The stage-RD_LAT entry qualifies i_dout.
- Expected data: Fibonacci LFSR, 16 bits, next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Expected word for address k = lfsr[DATA_W-1:0] after k advances from SEED.
  - The LFSR advances only on a valid compare.
- On a mismatch, o_err_cnt increments. The counter cannot overflow (max 2^ADDR_W fits ADDR_W+1 bits).
- On the first mismatch only, capture o_first_err_addr and set o_first_err_vld.
- i_abort in READ/DRAIN/DONE → IDLE next cycle:
  - o_en=0, pipeline valids cleared, no o_done.
  - o_pass stays 0; counters keep partial values.
- i_abort has priority over i_start when both are asserted.
- i_start outside IDLE is ignored.

## Timing
- Reset values of all outputs are 0: o_en, o_we, o_addr, o_busy, o_done, o_pass, o_err_cnt, o_first_err_addr, o_first_err_vld. FSM = IDLE, LFSR = SEED, pipeline valids = 0.
- Cycle numbering: cycle 0 is the edge sampling i_start=1.
- Address k is presented with o_en=1 during cycle k+1.
- Word k is compared at the edge ending cycle k+1+RD_LAT.
- Last compare ends cycle 2^ADDR_W+RD_LAT.
- o_done is high in cycle 2^ADDR_W+RD_LAT+1 (258 for defaults).
- o_busy falls in the same cycle o_done pulses.
- o_err_cnt and o_first_err_* update one cycle after the compare edge. They are stable when o_done is high.
- Reset assertion mid-sweep clears everything immediately (asynchronous); no o_done.

## Structure
- Shared package holds:
  - The LFSR tap/next-state function, shared with the pattern writer so both generate an identical sequence.
  - State encoding constants.
  - Default SEED.
- Natural sub-module: lfsr16 (load, advance enable, 16-bit state), instanced here and in the writer.
- FSM, address counter, latency pipeline and compare/capture logic stay in ram_read_checker.

## Test plan
- Behavioral RAM preloaded with the correct LFSR sequence, RD_LAT=1, start → o_done in cycle 258, o_pass=1, o_err_cnt=0, o_first_err_vld=0.
- Single corruption at address 0x37 (bit 0 flipped) → o_err_cnt=1, o_first_err_addr=0x37, o_first_err_vld=1, o_pass=0.
- Corrupt addresses 0x00 and 0xFF → o_err_cnt=2, o_first_err_addr=0x00. Checks the first/last boundary and that no wrap to address 0 occurs after 0xFF.
- RD_LAT=2 with a registered-output RAM model, 0x80 corrupted → o_done in cycle 259, o_err_cnt=1, o_first_err_addr=0x80.
- Control-input checks:
  - i_abort at o_addr=100 → o_en=0 next cycle, o_busy=0, no o_done.
  - Second i_start accepted afterwards, with a full clean sweep passing.
  - i_start pulsed mid-sweep is ignored.
- Reset in the middle of a sweep: i_rst_n low at o_addr=50 → all outputs 0 immediately. After release, a start gives a normal 258-cycle pass.
